// File: rtl/prime_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prime_pkg
// Purpose  : Shared FSM state encoding and default operand width.
// Revision : 1.0 - initial release
// ============================================================================
package prime_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam int C_DEFAULT_WIDTH = 32;

endpackage
`default_nettype wire

// File: rtl/prime_div_engine.sv
`default_nettype none
// ============================================================================
// Module   : prime_div_engine
// Purpose  : Iterative trial-division engine, one divisor per cycle.
//            PRIME_ODD_SKIP_EN: step divisor 2,3,5,7,... instead of 2,3,4,...
// Revision : 1.0 - initial release
// ============================================================================
module prime_div_engine
  import prime_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic             is_prime
);

  logic [WIDTH-1:0]   r_n;
  logic [WIDTH-1:0]   r_d;
  logic               r_active;
  logic [WIDTH-1:0]   w_d_next;
  logic [2*WIDTH-1:0] w_sq;
  logic               w_lt2;
  logic               w_over;
  logic               w_div;

  // Rules are tested in priority order: n<2, d*d>n, n%d==0.
  always_comb begin
    w_sq     = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_d};
    w_lt2    = (r_n < WIDTH'(2));
    w_over   = (w_sq > {{WIDTH{1'b0}}, r_n});
    w_div    = ((r_n % r_d) == '0);
    done     = r_active & (w_lt2 | w_over | w_div);
    is_prime = ~w_lt2 & w_over;
`ifdef PRIME_ODD_SKIP_EN
    w_d_next = (r_d == WIDTH'(2)) ? WIDTH'(3) : (r_d + WIDTH'(2));
`else
    w_d_next = r_d + WIDTH'(1);
`endif
  end

  // r_d never resets to zero so the modulo operand is always valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_n      <= '0;
      r_d      <= WIDTH'(2);
    end else if (start) begin
      r_active <= 1'b1;
      r_n      <= n;
      r_d      <= WIDTH'(2);
    end else if (done) begin
      r_active <= 1'b0;
    end else if (r_active) begin
      r_d      <= w_d_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prime_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prime_req_arbiter
// Purpose  : Round-robin sharing of one prime engine among NREQ requesters.
//            PRIME_ODD_SKIP_EN (in prime_div_engine) only changes latency.
// Revision : 1.0 - initial release
// ============================================================================
module prime_req_arbiter
  import prime_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = C_DEFAULT_WIDTH,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_num,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_num,
  output logic                  resp_prime,
  output logic                  busy,
  output logic [WIDTH-1:0]      prime_count
);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_resp_id;
  logic [WIDTH-1:0] r_resp_num;
  logic             r_resp_prime;
  logic [WIDTH-1:0] r_prime_count;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_grant_idx;
  logic             w_grant_any;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_num;
  logic             w_done;
  logic             w_is_prime;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_idx       = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_idx]) begin
        w_grant_idx = w_idx;
        w_grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_accept  = (r_state == S_IDLE) & w_grant_any & ~rst;
    req_ready = '0;
    w_sel_num = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == IDW'(i)) begin
        req_ready[i] = w_accept;
        w_sel_num    = req_num[i*WIDTH +: WIDTH];
      end
    end
  end

  prime_div_engine #(
    .WIDTH    (WIDTH)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (w_accept),
    .n        (w_sel_num),
    .done     (w_done),
    .is_prime (w_is_prime)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_next = S_CHECK;
      S_CHECK: if (w_done)     w_state_next = S_RESP;
      S_RESP:  if (resp_ready) w_state_next = S_IDLE;
      default:                 w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr         <= '0;
      r_resp_id     <= '0;
      r_resp_num    <= '0;
      r_resp_prime  <= 1'b0;
      r_prime_count <= '0;
    end else begin
      if (w_accept) begin
        r_ptr        <= (w_grant_idx == IDW'(NREQ - 1)) ? '0 : (w_grant_idx + IDW'(1));
        r_resp_id    <= w_grant_idx;
        r_resp_num   <= w_sel_num;
        r_resp_prime <= 1'b0;
      end
      if ((r_state == S_CHECK) && w_done) begin
        r_resp_prime <= w_is_prime;
      end
      if ((r_state == S_RESP) && resp_ready && r_resp_prime) begin
        r_prime_count <= r_prime_count + WIDTH'(1);
      end
    end
  end

  assign resp_valid  = (r_state == S_RESP);
  assign busy        = (r_state != S_IDLE);
  assign resp_id     = r_resp_id;
  assign resp_num    = r_resp_num;
  assign resp_prime  = r_resp_prime;
  assign prime_count = r_prime_count;

endmodule
`default_nettype wire

// File: tb/tb_prime_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prime_req_arbiter
// Purpose  : Directed scoreboard bench for prime_req_arbiter (NREQ=4, WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prime_req_arbiter;

  localparam int C_NREQ = 4;
  localparam int C_W    = 32;

  typedef struct packed {
    logic [1:0]     id;
    logic [C_W-1:0] num;
    logic           prime;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [C_NREQ-1:0]     req_valid;
  logic [C_NREQ*C_W-1:0] req_num;
  logic [C_NREQ-1:0]     req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [1:0]            resp_id;
  logic [C_W-1:0]        resp_num;
  logic                  resp_prime;
  logic                  busy;
  logic [C_W-1:0]        prime_count;

  exp_t           q[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  logic [C_W-1:0] exp_pcount = '0;

  prime_req_arbiter #(
    .NREQ        (C_NREQ),
    .WIDTH       (C_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_num     (req_num),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_num    (resp_num),
    .resp_prime  (resp_prime),
    .busy        (busy),
    .prime_count (prime_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pcount = '0;
      end else if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          check("unexpected_resp", 64'(resp_num), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("resp_id", 64'(resp_id), 64'(e.id));
          check("resp_num", 64'(resp_num), 64'(e.num));
          check("resp_prime", 64'(resp_prime), 64'(e.prime));
          check("prime_count_pre", 64'(prime_count), 64'(exp_pcount));
          if (e.prime) exp_pcount = exp_pcount + 1;
        end
      end
    end
  end

  task automatic set_req(input int id, input logic [C_W-1:0] n);
    req_valid[id]            = 1'b1;
    req_num[id*C_W +: C_W]   = n;
  endtask

  // Waits for a grant, checks it is the expected requester, optionally queues
  // the expected response, and returns just after the accept edge.
  task automatic wait_accept(input int id, input logic [C_W-1:0] n, input logic p, input bit push);
    exp_t e;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    check($sformatf("grant_%0d", id), 64'(req_ready), 64'(1) << id);
    if (push && req_ready == (C_NREQ'(1) << id)) begin
      e.id = 2'(id); e.num = n; e.prime = p;
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_single(input int id, input logic [C_W-1:0] n, input logic p, input int k);
    int lat;
    lat = -1;
    set_req(id, n);
    wait_accept(id, n, p, 1'b1);
    req_valid[id] = 1'b0;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    check($sformatf("latency_n%0d", n), 64'(lat), 64'(k + 1));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    resp_ready = 1'b1;
    req_valid  = '1;
    req_num    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_resp_num", 64'(resp_num), 64'd0);
    check("rst_resp_prime", 64'(resp_prime), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_prime_count", 64'(prime_count), 64'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single prime request on requester 0.
`ifdef PRIME_ODD_SKIP_EN
    do_single(0, 32'd17, 1'b1, 3);
`else
    do_single(0, 32'd17, 1'b1, 4);
`endif
    check("pcount_after_17", 64'(prime_count), 64'd1);

    // Edge operands on requester 2, each resolved in one trial.
    do_single(2, 32'd18, 1'b0, 1);
    do_single(2, 32'd0,  1'b0, 1);
    do_single(2, 32'd1,  1'b0, 1);
    do_single(2, 32'd2,  1'b1, 1);
    do_single(2, 32'd4,  1'b0, 1);
    check("pcount_after_edges", 64'(prime_count), 64'd2);

    // Backpressure: stall 10 cycles in RESP while requester 3 waits.
    resp_ready = 1'b0;
    set_req(1, 32'd19);
    wait_accept(1, 32'd19, 1'b1, 1'b1);
    req_valid[1] = 1'b0;
    set_req(3, 32'd5);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("stall_valid", 64'(resp_valid), 64'd1);
      check("stall_id", 64'(resp_id), 64'd1);
      check("stall_num", 64'(resp_num), 64'd19);
      check("stall_prime", 64'(resp_prime), 64'd1);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_pcount", 64'(prime_count), 64'd2);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    wait_accept(3, 32'd5, 1'b1, 1'b1);
    req_valid[3] = 1'b0;
    check("release_valid_low", 64'(resp_valid), 64'd0);
    check("release_pcount", 64'(prime_count), 64'd3);
    drain();
    check("pcount_before_rst", 64'(prime_count), 64'd4);

    // Reset mid-CHECK discards the request.
    set_req(1, 32'd2147483647);
    wait_accept(1, 32'd2147483647, 1'b1, 1'b0);
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midcheck_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_req_ready", 64'(req_ready), 64'd0);
    check("mrst_resp_valid", 64'(resp_valid), 64'd0);
    check("mrst_resp_id", 64'(resp_id), 64'd0);
    check("mrst_resp_num", 64'(resp_num), 64'd0);
    check("mrst_resp_prime", 64'(resp_prime), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_prime_count", 64'(prime_count), 64'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mrst_no_resp", 64'(resp_valid), 64'd0);

    // Round-robin from ptr=0 with all four requesters pending.
    set_req(0, 32'd19);
    set_req(1, 32'd20);
    set_req(2, 32'd23);
    set_req(3, 32'd25);
    wait_accept(0, 32'd19, 1'b1, 1'b1);
    wait_accept(1, 32'd20, 1'b0, 1'b1);
    wait_accept(2, 32'd23, 1'b1, 1'b1);
    wait_accept(3, 32'd25, 1'b0, 1'b1);
    wait_accept(0, 32'd19, 1'b1, 1'b1);
    req_valid = '0;
    drain();
    check("pcount_after_rr", 64'(prime_count), 64'd3);

    // Square of a prime: composite found at d=7.
`ifdef PRIME_ODD_SKIP_EN
    do_single(0, 32'd49, 1'b0, 4);
`else
    do_single(0, 32'd49, 1'b0, 6);
`endif
    check("pcount_final", 64'(prime_count), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
